window_scan_counter: RTL and testbench

Parametrised raster/window address generator for the edge-detection datapath. It walks every interior pixel of a runtime-sized frame. For each pixel it emits the K×K kernel taps (coordinates plus linear memory address), one tap per accepted handshake. It sits between the control FSM and the Avalon read master, and replaces the fixed-size dual X/Y counter with runtime frame size, kernel sub-scan, backpressure and abort.

---
 rtl/window_scan_counter_pkg.sv | 21 ++
 rtl/window_scan_counter_wrap_counter.sv | 38 +++
 rtl/window_scan_counter.sv | 203 ++++++++++++++++++++
 tb/tb_window_scan_counter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/window_scan_counter_pkg.sv
// Shared definitions for the window scan address generator: FSM states and
// the parameter-derived widths used by the top and the bench.
package window_scan_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a kernel tap index: max(1, clog2(k)).
    function automatic int calc_kw(input int k);
        return ($clog2(k) < 1) ? 1 : $clog2(k);
    endfunction

    // Border that the window centre keeps from each frame edge.
    function automatic int calc_margin(input int k);
        return (k - 1) / 2;
    endfunction

endpackage

// File: rtl/window_scan_counter_wrap_counter.sv
// Loadable up-counter that returns to its start value after reaching a runtime
// end value; wrap_o is the carry into the next counter of the chain.
module wrap_counter #(
    parameter int W         = 8,
    parameter int START_VAL = 0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] end_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] START_V = W'(START_VAL);

    logic [W-1:0] r_count;

    assign wrap_o  = inc_i && (r_count == end_i);
    assign count_o = r_count;

    // NOTE: clocked state uses non-blocking assignments so every register in
    // the chain samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= START_V;
        end else if (inc_i) begin
            r_count <= wrap_o ? START_V : r_count + W'(1);
        end
    end

endmodule

// File: rtl/window_scan_counter.sv
// Raster/window address generator: walks every interior pixel of a runtime
// sized frame and emits its KxK kernel taps, one per accepted handshake.
module window_scan_counter
    import window_scan_counter_pkg::*;
#(
    parameter  int X_W    = 10,
    parameter  int Y_W    = 10,
    parameter  int K      = 3,
    parameter  int ADDR_W = 20,
    localparam int KW     = calc_kw(K)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              clear_i,
    input  logic [X_W-1:0]    width_i,
    input  logic [Y_W-1:0]    height_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [X_W-1:0]    X_o,
    output logic [Y_W-1:0]    Y_o,
    output logic [KW-1:0]     KX_o,
    output logic [KW-1:0]     KY_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_tap_o,
    output logic              busy_o,
    output logic              finished_o
);

    localparam int                M          = calc_margin(K);
    localparam logic [KW-1:0]     TAP_END    = KW'(K - 1);
    localparam logic [ADDR_W-1:0] ROW_REWIND = ADDR_W'(K - 1);

    state_t r_state;
    state_t w_next_state;

    logic [X_W-1:0]    r_width;
    logic [Y_W-1:0]    r_height;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_pix_base;

    logic              w_dims_ok;
    logic              w_hs;
    logic              w_load;
    logic              w_clr;
    logic              w_kx_wrap;
    logic              w_ky_wrap;
    logic              w_x_wrap;
    logic              w_y_wrap;
    logic [X_W-1:0]    w_x_end;
    logic [Y_W-1:0]    w_y_end;
    logic [ADDR_W-1:0] w_width_a;
    logic [KW-1:0]     w_kx;
    logic [KW-1:0]     w_ky;
    logic [X_W-1:0]    w_x;
    logic [Y_W-1:0]    w_y;

    assign w_dims_ok = (width_i >= X_W'(K)) && (height_i >= Y_W'(K));
    assign w_x_end   = r_width - X_W'(M + 1);
    assign w_y_end   = r_height - Y_W'(M + 1);
    assign w_width_a = ADDR_W'(r_width);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_clr        = 1'b0;
        w_hs         = (r_state == ST_RUN) && ready_i;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (w_dims_ok) begin
                        w_next_state = ST_RUN;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (w_y_wrap) begin
                    w_next_state = ST_DONE;
                    w_clr        = 1'b1;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        // Abort overrides a simultaneous start or final handshake.
        if (clear_i) begin
            w_next_state = ST_IDLE;
            w_load       = 1'b0;
            w_clr        = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_width  <= '0;
            r_height <= '0;
        end else if (r_state == ST_IDLE && start_i && !clear_i) begin
            r_width  <= width_i;
            r_height <= height_i;
        end
    end

    // Tap address tracked incrementally: r_row_base is the top-left tap of the
    // first window in the current row, r_pix_base that of the current window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr     <= '0;
            r_row_base <= '0;
            r_pix_base <= '0;
        end else if (w_clr) begin
            r_addr     <= '0;
            r_row_base <= '0;
            r_pix_base <= '0;
        end else if (w_load) begin
            r_addr     <= base_i;
            r_row_base <= base_i;
            r_pix_base <= base_i;
        end else if (w_hs) begin
            if (!w_kx_wrap) begin
                r_addr <= r_addr + ADDR_W'(1);
            end else if (!w_ky_wrap) begin
                r_addr <= r_addr + w_width_a - ROW_REWIND;
            end else if (!w_x_wrap) begin
                r_pix_base <= r_pix_base + ADDR_W'(1);
                r_addr     <= r_pix_base + ADDR_W'(1);
            end else begin
                r_row_base <= r_row_base + w_width_a;
                r_pix_base <= r_row_base + w_width_a;
                r_addr     <= r_row_base + w_width_a;
            end
        end
    end

    wrap_counter #(.W(KW), .START_VAL(0)) u_kx (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_hs),
        .clear_i (w_clr),
        .load_i  (w_load),
        .end_i   (TAP_END),
        .count_o (w_kx),
        .wrap_o  (w_kx_wrap)
    );

    wrap_counter #(.W(KW), .START_VAL(0)) u_ky (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_kx_wrap),
        .clear_i (w_clr),
        .load_i  (w_load),
        .end_i   (TAP_END),
        .count_o (w_ky),
        .wrap_o  (w_ky_wrap)
    );

    wrap_counter #(.W(X_W), .START_VAL(M)) u_x (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_ky_wrap),
        .clear_i (w_clr),
        .load_i  (w_load),
        .end_i   (w_x_end),
        .count_o (w_x),
        .wrap_o  (w_x_wrap)
    );

    wrap_counter #(.W(Y_W), .START_VAL(M)) u_y (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (w_x_wrap),
        .clear_i (w_clr),
        .load_i  (w_load),
        .end_i   (w_y_end),
        .count_o (w_y),
        .wrap_o  (w_y_wrap)
    );

    assign valid_o    = (r_state == ST_RUN);
    assign busy_o     = (r_state != ST_IDLE);
    assign finished_o = (r_state == ST_DONE);
    assign X_o        = w_x;
    assign Y_o        = w_y;
    assign KX_o       = w_kx;
    assign KY_o       = w_ky;
    assign addr_o     = r_addr;
    assign last_tap_o = valid_o && (w_kx == TAP_END) && (w_ky == TAP_END);

endmodule

// File: tb/tb_window_scan_counter.sv
// Self-checking bench: directed and randomized scans of a K=3 and a K=1
// instance compared against a nested-loop reference model of the tap stream.
module tb_window_scan_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [9:0]  width = '0;
    logic [9:0]  height = '0;
    logic [19:0] base = '0;

    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        valid, last, busy, fin;
    logic [9:0]  x, y;
    logic [1:0]  kx, ky;
    logic [19:0] addr;

    logic        k1_start = 1'b0;
    logic        k1_ready = 1'b0;
    logic        k1_valid, k1_last, k1_busy, k1_fin;
    logic [9:0]  k1_x, k1_y;
    logic [0:0]  k1_kx, k1_ky;
    logic [19:0] k1_addr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          x;
        int          y;
        int          kx;
        int          ky;
        logic [19:0] addr;
        bit          last;
    } tap_t;

    tap_t exp_q[$];

    always #5 clk = ~clk;

    window_scan_counter #(.X_W(10), .Y_W(10), .K(3), .ADDR_W(20)) dut3 (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .clear_i    (clr),
        .width_i    (width),
        .height_i   (height),
        .base_i     (base),
        .ready_i    (ready),
        .valid_o    (valid),
        .X_o        (x),
        .Y_o        (y),
        .KX_o       (kx),
        .KY_o       (ky),
        .addr_o     (addr),
        .last_tap_o (last),
        .busy_o     (busy),
        .finished_o (fin)
    );

    window_scan_counter #(.X_W(10), .Y_W(10), .K(1), .ADDR_W(20)) dut1 (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (k1_start),
        .clear_i    (clr),
        .width_i    (width),
        .height_i   (height),
        .base_i     (base),
        .ready_i    (k1_ready),
        .valid_o    (k1_valid),
        .X_o        (k1_x),
        .Y_o        (k1_y),
        .KX_o       (k1_kx),
        .KY_o       (k1_ky),
        .addr_o     (k1_addr),
        .last_tap_o (k1_last),
        .busy_o     (k1_busy),
        .finished_o (k1_fin)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference tap stream straight from the scan-order definition.
    task automatic build_model(input int k, input int w, input int h, input logic [19:0] b);
        int   m;
        tap_t t;
        m = (k - 1) / 2;
        exp_q.delete();
        if (w < k || h < k) return;
        for (int yy = m; yy <= h - 1 - m; yy++)
            for (int xx = m; xx <= w - 1 - m; xx++)
                for (int jy = 0; jy < k; jy++)
                    for (int jx = 0; jx < k; jx++) begin
                        t.x    = xx;
                        t.y    = yy;
                        t.kx   = jx;
                        t.ky   = jy;
                        t.addr = b + 20'((yy + jy - m) * w + (xx + jx - m));
                        t.last = (jx == k - 1) && (jy == k - 1);
                        exp_q.push_back(t);
                    end
    endtask

    task automatic check_tap3(input int i);
        check("valid", 64'(valid), 64'(1));
        check("x", 64'(x), 64'(exp_q[i].x));
        check("y", 64'(y), 64'(exp_q[i].y));
        check("kx", 64'(kx), 64'(exp_q[i].kx));
        check("ky", 64'(ky), 64'(exp_q[i].ky));
        check("addr", 64'(addr), 64'(exp_q[i].addr));
        check("last_tap", 64'(last), 64'(exp_q[i].last));
    endtask

    task automatic check_zero3(input string tag);
        check(tag, 64'({valid, busy, fin, last, x, y, kx, ky, addr}), 64'(0));
    endtask

    // abort_kind: 0 none, 1 clear_i at tap abort_at, 2 rst_i at tap abort_at
    task automatic scan3(input int w, input int h, input logic [19:0] b, input int rdy_pct,
                         input int hold_at, input int abort_kind, input int abort_at);
        int n, idx, cycles, held;
        bit r;
        build_model(3, w, h, b);
        n = exp_q.size();
        @(negedge clk);
        start = 1'b1; width = 10'(w); height = 10'(h); base = b;
        @(negedge clk);
        start = 1'b0; width = 10'($urandom); height = 10'($urandom); base = 20'($urandom);
        if (n == 0) begin
            check("degen_valid", 64'(valid), 64'(0));
            check("degen_finished", 64'(fin), 64'(1));
            @(negedge clk);
            check("degen_idle", 64'({busy, fin, valid}), 64'(0));
            return;
        end
        idx = 0; cycles = 0; held = 0;
        while (idx < n && cycles < 2000) begin
            check_tap3(idx);
            if (abort_kind != 0 && idx == abort_at) begin
                start = 1'b0;
                ready = 1'b1;
                if (abort_kind == 1) begin
                    clr = 1'b1;
                    @(negedge clk);
                    clr = 1'b0;
                    check_zero3("clear_outputs");
                    @(negedge clk);
                    check_zero3("clear_idle");
                end else begin
                    #2 rst = 1'b1;
                    #1 check_zero3("reset_async");
                    @(negedge clk);
                    rst = 1'b0;
                    check_zero3("reset_held");
                end
                return;
            end
            if (idx == hold_at && held < 3) begin
                r = 1'b0;
                held++;
            end else begin
                r = ($urandom_range(99) < rdy_pct);
            end
            ready = r;
            start = 1'($urandom_range(1));
            width = 10'($urandom); height = 10'($urandom); base = 20'($urandom);
            @(negedge clk);
            cycles++;
            if (r) idx++;
        end
        start = 1'b0;
        ready = 1'($urandom_range(1));
        if (idx < n) check("scan_timeout", 64'(idx), 64'(n));
        check("done_valid", 64'(valid), 64'(0));
        check("done_finished", 64'(fin), 64'(1));
        check("done_busy", 64'(busy), 64'(1));
        @(negedge clk);
        check("idle_after_done", 64'({busy, fin, valid}), 64'(0));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_zero3("reset_k3");
        check("reset_k1", 64'({k1_valid, k1_busy, k1_fin, k1_last, k1_addr}), 64'(0));
        rst = 1'b0;

        scan3(4, 4, 20'd100, 100, -1, 0, 0);
        scan3(4, 4, 20'd100, 100, 4, 0, 0);
        scan3(2, 5, 20'd100, 100, -1, 0, 0);
        scan3(5, 2, 20'd100, 100, -1, 0, 0);
        scan3(4, 4, 20'd100, 100, -1, 1, 9);
        scan3(4, 4, 20'd100, 100, -1, 0, 0);
        scan3(4, 4, 20'd100, 100, -1, 2, 6);
        scan3(4, 4, 20'd100, 100, -1, 0, 0);

        // K=1: every tap is the last of its pixel; a start during RUN is ignored.
        build_model(1, 3, 2, 20'd0);
        @(negedge clk);
        k1_start = 1'b1; k1_ready = 1'b1; width = 10'd3; height = 10'd2; base = 20'd0;
        @(negedge clk);
        k1_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("k1_valid", 64'(k1_valid), 64'(1));
            check("k1_xy", 64'({k1_x, k1_y}), 64'({10'(exp_q[i].x), 10'(exp_q[i].y)}));
            check("k1_kxky", 64'({k1_kx, k1_ky}), 64'(0));
            check("k1_addr", 64'(k1_addr), 64'(exp_q[i].addr));
            check("k1_last", 64'(k1_last), 64'(1));
            k1_start = (i == 2);
            @(negedge clk);
        end
        k1_start = 1'b0;
        check("k1_done", 64'({k1_valid, k1_fin}), 64'(1));
        @(negedge clk);
        check("k1_idle", 64'({k1_busy, k1_fin}), 64'(0));

        for (int i = 0; i < 5; i++)
            scan3(int'($urandom_range(7, 3)), int'($urandom_range(7, 3)), 20'($urandom), 70, -1, 0, 0);
        scan3(5, 4, 20'hFFFF8, 60, 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
